serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor; the inverse of the ripple full_adder
//  datapath. Computes Diff = A - B one bit per clock, LSB first, through a single
//  full-subtractor (borrow) stage.
//  Sits beside the adder in the ALU/calculator datapath for area-cheap subtraction.
//  Uses a start/busy/done handshake with the controlling FSM.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//  clk    in   1      system clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled when busy=0
//  A      in   WIDTH  minuend; captured on accepted start
//  B      in   WIDTH  subtrahend; captured on accepted start
//  busy   out  1      high while a subtraction is in progress
//  done   out  1      one-cycle pulse; Diff/Bout/Ovf valid from this cycle
//  Diff   out  WIDTH  A - B mod 2^WIDTH
//  Bout   out  1      final borrow (1 = unsigned A < B)
//  Ovf    out  1      signed overflow of A - B
// BEHAVIOUR
//  Reset: one clock and reset; reset is asynchronous and active-high.
//  - On rst, all outputs = 0; state = IDLE; internal shift regs, count, borrow = 0.
//  - rst mid-operation aborts immediately. No done is produced; results are lost.
//  FSM states: IDLE, SHIFT, DONE.
//  - busy = (state==SHIFT).
//  - done = (state==DONE); it is registered and lasts exactly one cycle.
//  - IDLE: start=1 -> latch A,B into shift regs; borrow=0; count=0; go to SHIFT.
//  - SHIFT: each edge processes bit a0,b0 (current LSBs):
//      d  = a0 ^ b0 ^ br
//      br <= (~a0 & b0) | (~(a0 ^ b0) & br)
//    d shifts into the MSB of the result reg; operand regs shift right; count++.
//    When count==WIDTH-1, that edge also:
//      - copies the final result to Diff;
//      - sets Bout = final br;
//      - sets Ovf = (A[MSB]!=B[MSB]) & (Diff[MSB]!=A[MSB]), using captured operands;
//      - moves to DONE.
//  - DONE: returns to IDLE next edge. start=1 here is accepted, same as IDLE,
//    and goes straight to SHIFT. This gives back-to-back throughput of one result
//    every WIDTH+1 cycles.
//  Latency: start sampled at edge k -> done high after edge k+WIDTH.
//  Outputs Diff/Bout/Ovf change only at completion and hold until the next
//  completion. During SHIFT they still show the previous result.
//  start while busy=1 is ignored. A/B changes during SHIFT have no effect.
//  Counter is sized clog2(WIDTH)+1 bits. The count register never wraps.
//  Full-width arithmetic only; no saturation.
// TESTING
//  - WIDTH=8: A=100, B=37, start pulse -> done exactly 8 clocks later;
//    Diff=63, Bout=0, Ovf=0; busy high for 8 cycles.
//  - A=5, B=7 -> Diff=8'hFE, Bout=1, Ovf=0.
//  - A=8'h80, B=8'h01 -> Diff=8'h7F, Bout=0, Ovf=1.
//    Then A=8'h7F, B=8'hFF -> Diff=8'h80, Bout=1, Ovf=1.
//  - A=0, B=0 -> Diff=0, Bout=0, Ovf=0.
//    Then A=B=8'hFF -> Diff=0, Bout=0.
//  - Assert start again 3 cycles into a run with new A/B -> ignored; first result
//    is unaffected. start held high in the DONE cycle -> second run begins; its
//    done comes 9 cycles after the first done.
//  - Assert rst on SHIFT cycle 4 -> outputs all 0 asynchronously; no done pulse.
//    After release, a new start computes correctly.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B, LSB first, one bit per clock.
// Start is accepted in IDLE or DONE; done pulses WIDTH clocks after the accepting edge.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CW-1:0]    count;
  logic             br, br_nxt, d;
  logic             a_msb, b_msb;
  logic             last, accept;

  // Single full-subtractor stage on the current operand LSBs
  always_comb begin
    d       = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_nxt = {d, res_sr[WIDTH-1:1]};
    last    = (count == CW'(WIDTH - 1));
    accept  = start & (state != SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      count  <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
      count  <= '0;
      br     <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      br     <= br_nxt;
      count  <= count + 1'b1;
      // Published results change only here and hold until the next completion
      if (last) begin
        Diff <= res_nxt;
        Bout <= br_nxt;
        Ovf  <= (a_msb != b_msb) & (res_nxt[WIDTH-1] != a_msb);
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed expectations.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       busy, done;
  logic [7:0] Diff;
  logic       Bout, Ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int busy_cnt;
  int done_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start at a negedge, then wait (bounded) for done, counting cycles.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic bo, input logic ov);
    check({tag, "_lat"}, cyc - 1, 8);
    check({tag, "_diff"}, Diff, d);
    check({tag, "_bout"}, Bout, bo);
    check({tag, "_ovf"}, Ovf, ov);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", Diff, 8'h00);
    check("rst_bout", Bout, 1'b0);
    check("rst_ovf",  Ovf,  1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd100, 8'd37);
    check("t1_busy_cycles", busy_cnt, 8);
    check_result("t1", 8'd63, 1'b0, 1'b0);

    run_op(8'd5, 8'd7);
    check_result("t2", 8'hFE, 1'b1, 1'b0);

    run_op(8'h80, 8'h01);
    check_result("t3", 8'h7F, 1'b0, 1'b1);

    run_op(8'h7F, 8'hFF);
    check_result("t4", 8'h80, 1'b1, 1'b1);

    run_op(8'h00, 8'h00);
    check_result("t5", 8'h00, 1'b0, 1'b0);

    run_op(8'hFF, 8'hFF);
    check_result("t6", 8'h00, 1'b0, 1'b0);

    // start while busy is ignored; previous result visible during SHIFT
    run_op(8'hFE, 8'h01);
    check_result("t7a", 8'hFD, 1'b0, 1'b0);
    A = 8'd100; B = 8'd37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t7_busy_mid", busy, 1'b1);
    check("t7_hold_diff", Diff, 8'hFD);
    A = 8'd1; B = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'd50; B = 8'd60;
    cyc = 4;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_result("t7", 8'd63, 1'b0, 1'b0);

    // Back-to-back: start held during DONE
    A = 8'd10; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t8a_lat", cyc - 1, 8);
    check("t8a_diff", Diff, 8'd7);
    A = 8'd20; B = 8'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t8_busy_after_done", busy, 1'b1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t8b_done_gap", cyc, 9);
    check("t8b_diff", Diff, 8'hE2);
    check("t8b_bout", Bout, 1'b1);
    check("t8b_ovf",  Ovf,  1'b0);
    @(negedge clk);

    // Reset mid-SHIFT aborts asynchronously with no done
    A = 8'd9; B = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("t9_rst_busy", busy, 1'b0);
    check("t9_rst_diff", Diff, 8'h00);
    check("t9_rst_bout", Bout, 1'b0);
    check("t9_rst_ovf",  Ovf,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("t9_no_done", done_cnt, 0);

    run_op(8'd9, 8'd4);
    check_result("t10", 8'd5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
